// File: rtl/seg_pkg.sv
// Shared 7-segment constants: blank pattern and active-low {g,f,e,d,c,b,a} hex font.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] HEX_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/digit_scan_driver_if.sv
// Display data bundle between the value source (master) and the scan driver (slave).
interface digit_scan_driver_if #(
  parameter int N_DIGITS = 4,
  parameter int BRIGHT_W = 3
);
  localparam int S_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [4*N_DIGITS-1:0] value;
  logic [N_DIGITS-1:0]   dp;
  logic [N_DIGITS-1:0]   digit_en;
  logic                  lz_blank;
  logic [BRIGHT_W-1:0]   bright;
  logic [S_W-1:0]        S;
  logic [N_DIGITS-1:0]   AN;
  logic [6:0]            SEG;
  logic                  DP;
  logic                  frame_start;

  modport master (
    output value, dp, digit_en, lz_blank, bright,
    input  S, AN, SEG, DP, frame_start
  );

  modport slave (
    input  value, dp, digit_en, lz_blank, bright,
    output S, AN, SEG, DP, frame_start
  );
endinterface

// File: rtl/digit_scan_driver_hex7seg.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = HEX_FONT[nibble];
endmodule

// File: rtl/digit_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with PWM brightness,
// leading-zero blanking, per-digit enable, ghost guard and frame-coherent input snapshot.
module digit_scan_driver
  import seg_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int DIV      = 25000,
  parameter int BRIGHT_W = 3
) (
  input  logic                clk,
  input  logic                clr_n,
  digit_scan_driver_if.slave  bus
);
  localparam int S_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);
  localparam logic [S_W-1:0]   S_MAX   = S_W'(N_DIGITS - 1);

  logic [PRE_W-1:0]      pre;
  logic [BRIGHT_W-1:0]   sub;
  logic [S_W-1:0]        s_idx;
  logic                  pre_end, slot_end, frame_wrap;

  logic                  load_pending;
  logic [4*N_DIGITS-1:0] sh_value;
  logic [N_DIGITS-1:0]   sh_dp, sh_en;
  logic                  sh_lz;
  logic [BRIGHT_W-1:0]   sh_bright;

  logic [N_DIGITS-1:0]   zb, vis, lit;
  logic [3:0]            cur_nib;
  logic [6:0]            font_seg;
  logic                  guard, on_p0;

  logic [N_DIGITS-1:0]   an_p1;
  logic [6:0]            seg_p1;
  logic                  dp_p1, fs_p1;

  assign pre_end    = (pre == PRE_MAX);
  assign slot_end   = pre_end && (sub == '1);
  assign frame_wrap = slot_end && (s_idx == S_MAX);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pre   <= '0;
      sub   <= '0;
      s_idx <= '0;
    end else begin
      if (pre_end) begin
        pre <= '0;
        sub <= sub + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
      if (slot_end) s_idx <= frame_wrap ? '0 : s_idx + 1'b1;
    end
  end

  // Snapshot only at frame boundaries so a half-updated value never shows.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      load_pending <= 1'b1;
      sh_value     <= '0;
      sh_dp        <= '0;
      sh_en        <= '0;
      sh_lz        <= 1'b0;
      sh_bright    <= '0;
    end else begin
      load_pending <= 1'b0;
      if (load_pending || frame_wrap) begin
        sh_value  <= bus.value;
        sh_dp     <= bus.dp;
        sh_en     <= bus.digit_en;
        sh_lz     <= bus.lz_blank;
        sh_bright <= bus.bright;
      end
    end
  end

  // A zero-blanked digit loses its glyph but still lights for its decimal point.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    zb  = '0;
    vis = '0;
    lit = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (sh_value[4*i +: 4] == 4'h0);
      zb[i]  = sh_lz && (i != 0) && upper_zero;
      vis[i] = sh_en[i] && !zb[i];
      lit[i] = sh_en[i] && (!zb[i] || sh_dp[i]);
    end
  end

  assign cur_nib = sh_value[{s_idx, 2'b00} +: 4];

  hex7seg u_font (
    .nibble (cur_nib),
    .seg    (font_seg)
  );

  assign guard = (pre == '0) && (sub == '0);
  assign on_p0 = lit[s_idx] && (sub <= sh_bright) && !guard;

  // Stage boundary: counter state -> registered pin drivers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      an_p1  <= '1;
      seg_p1 <= SEG_BLANK;
      dp_p1  <= 1'b1;
      fs_p1  <= 1'b0;
    end else begin
      an_p1  <= on_p0 ? ~(N_DIGITS'(1) << s_idx) : '1;
      seg_p1 <= vis[s_idx] ? font_seg : SEG_BLANK;
      dp_p1  <= on_p0 ? ~sh_dp[s_idx] : 1'b1;
      fs_p1  <= frame_wrap;
    end
  end

  assign bus.S           = s_idx;
  assign bus.AN          = an_p1;
  assign bus.SEG         = seg_p1;
  assign bus.DP          = dp_p1;
  assign bus.frame_start = fs_p1;
endmodule

// File: tb/tb_digit_scan_driver.sv
// Directed bench for digit_scan_driver with N_DIGITS=4, DIV=4, BRIGHT_W=2 (16-clk slot, 64-clk frame).
module tb_digit_scan_driver;
  logic clk;
  logic clr_n;

  int errors = 0;
  int checks = 0;

  logic [3:0] an_s  [64];
  logic [6:0] seg_s [64];
  logic       dp_s  [64];
  logic       fs_s  [64];

  digit_scan_driver_if #(.N_DIGITS(4), .BRIGHT_W(2)) bus ();

  digit_scan_driver #(.N_DIGITS(4), .DIV(4), .BRIGHT_W(2)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_frame();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.frame_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.frame_start !== 1'b1) begin
      errors++;
      $display("FAIL frame_sync: frame_start=%b required 1", bus.frame_start);
    end
  endtask

  task automatic capture();
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      an_s[k]  = bus.AN;
      seg_s[k] = bus.SEG;
      dp_s[k]  = bus.DP;
      fs_s[k]  = bus.frame_start;
    end
  endtask

  function automatic int an_low(int d);
    int c = 0;
    for (int k = 0; k < 64; k++) if (an_s[k][d] == 1'b0) c++;
    return c;
  endfunction

  function automatic int an_illegal();
    int c = 0;
    for (int k = 0; k < 64; k++)
      if (an_s[k] != 4'hF && $countones(~an_s[k]) != 1) c++;
    return c;
  endfunction

  task automatic test_reset();
    bus.value = 16'h1234; bus.dp = 4'h0; bus.digit_en = 4'hF;
    bus.lz_blank = 1'b0; bus.bright = 2'd3;
    clr_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.AN !== 4'hF) begin errors++; $display("FAIL rst_an: got %h required f", bus.AN); end
    checks++; if (bus.SEG !== 7'h7F) begin errors++; $display("FAIL rst_seg: got %h required 7f", bus.SEG); end
    checks++; if (bus.DP !== 1'b1) begin errors++; $display("FAIL rst_dp: got %b required 1", bus.DP); end
    checks++; if (bus.frame_start !== 1'b0) begin errors++; $display("FAIL rst_fs: got %b required 0", bus.frame_start); end
    checks++; if (bus.S !== 2'd0) begin errors++; $display("FAIL rst_s: got %0d required 0", bus.S); end
    clr_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.AN !== 4'hF) begin errors++; $display("FAIL rel_guard_an: got %h required f", bus.AN); end
    @(negedge clk);
    checks++; if (bus.AN !== 4'b1110) begin errors++; $display("FAIL rel_first_an: got %b required 1110", bus.AN); end
    checks++; if (bus.SEG !== 7'h19) begin errors++; $display("FAIL rel_first_seg: got %h required 19", bus.SEG); end
  endtask

  task automatic test_scan();
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an;
    exp_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
    wait_frame();
    capture();
    for (int d = 0; d < 4; d++) begin
      exp_an = ~(4'b0001 << d);
      checks++; if (an_s[16*d] !== 4'hF) begin errors++; $display("FAIL scan_guard_d%0d: got %b required 1111", d, an_s[16*d]); end
      checks++; if (an_s[16*d+1] !== exp_an) begin errors++; $display("FAIL scan_an_d%0d: got %b required %b", d, an_s[16*d+1], exp_an); end
      checks++; if (an_low(d) !== 15) begin errors++; $display("FAIL scan_on_d%0d: low=%0d required 15", d, an_low(d)); end
      checks++; if (seg_s[16*d+1] !== exp_seg[d]) begin errors++; $display("FAIL scan_seg_d%0d: got %h required %h", d, seg_s[16*d+1], exp_seg[d]); end
    end
    checks++; if (an_illegal() !== 0) begin errors++; $display("FAIL scan_onehot: bad=%0d required 0", an_illegal()); end
  endtask

  task automatic test_brightness();
    bus.bright = 2'd0;
    wait_frame();
    capture();
    for (int d = 0; d < 4; d++) begin
      checks++; if (an_low(d) !== 3) begin errors++; $display("FAIL bright0_d%0d: low=%0d required 3", d, an_low(d)); end
    end
    bus.bright = 2'd1;
    wait_frame();
    capture();
    for (int d = 0; d < 4; d++) begin
      checks++; if (an_low(d) !== 7) begin errors++; $display("FAIL bright1_d%0d: low=%0d required 7", d, an_low(d)); end
    end
    bus.bright = 2'd3;
  endtask

  task automatic test_lz_blank();
    bus.value = 16'h0050; bus.lz_blank = 1'b1;
    wait_frame();
    capture();
    checks++; if (an_low(3) !== 0) begin errors++; $display("FAIL lz_d3_dark: low=%0d required 0", an_low(3)); end
    checks++; if (an_low(2) !== 0) begin errors++; $display("FAIL lz_d2_dark: low=%0d required 0", an_low(2)); end
    checks++; if (an_low(1) !== 15) begin errors++; $display("FAIL lz_d1_on: low=%0d required 15", an_low(1)); end
    checks++; if (seg_s[17] !== 7'h12) begin errors++; $display("FAIL lz_d1_seg: got %h required 12", seg_s[17]); end
    checks++; if (seg_s[1] !== 7'h40) begin errors++; $display("FAIL lz_d0_seg: got %h required 40", seg_s[1]); end
    checks++; if (seg_s[49] !== 7'h7F) begin errors++; $display("FAIL lz_d3_seg: got %h required 7f", seg_s[49]); end
    bus.value = 16'h0000;
    wait_frame();
    capture();
    checks++; if (an_low(1) !== 0) begin errors++; $display("FAIL lz0_d1_dark: low=%0d required 0", an_low(1)); end
    checks++; if (an_low(0) !== 15) begin errors++; $display("FAIL lz0_d0_on: low=%0d required 15", an_low(0)); end
    checks++; if (seg_s[1] !== 7'h40) begin errors++; $display("FAIL lz0_d0_seg: got %h required 40", seg_s[1]); end
    bus.lz_blank = 1'b0;
  endtask

  task automatic test_midframe();
    int fs_cnt;
    bus.value = 16'h1234;
    wait_frame();
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      an_s[k] = bus.AN; seg_s[k] = bus.SEG; fs_s[k] = bus.frame_start;
      if (k == 10) bus.value = 16'h5678;
    end
    fs_cnt = 0;
    for (int k = 0; k < 64; k++) if (fs_s[k] == 1'b1) fs_cnt++;
    checks++; if (seg_s[17] !== 7'h30) begin errors++; $display("FAIL mid_hold_d1: got %h required 30", seg_s[17]); end
    checks++; if (seg_s[49] !== 7'h79) begin errors++; $display("FAIL mid_hold_d3: got %h required 79", seg_s[49]); end
    checks++; if (fs_cnt !== 1) begin errors++; $display("FAIL fs_count: got %0d required 1", fs_cnt); end
    checks++; if (fs_s[63] !== 1'b1) begin errors++; $display("FAIL fs_pos: got %b required 1", fs_s[63]); end
    capture();
    checks++; if (seg_s[17] !== 7'h78) begin errors++; $display("FAIL mid_new_d1: got %h required 78", seg_s[17]); end
    checks++; if (seg_s[49] !== 7'h12) begin errors++; $display("FAIL mid_new_d3: got %h required 12", seg_s[49]); end
  endtask

  task automatic test_dp_enable();
    int dp_cnt, dp_bad;
    bus.value = 16'h1234; bus.dp = 4'b0100; bus.digit_en = 4'b1011;
    wait_frame();
    capture();
    dp_cnt = 0;
    for (int k = 0; k < 64; k++) if (dp_s[k] == 1'b0) dp_cnt++;
    checks++; if (an_low(2) !== 0) begin errors++; $display("FAIL en_d2_dark: low=%0d required 0", an_low(2)); end
    checks++; if (dp_cnt !== 0) begin errors++; $display("FAIL en_dp_dark: low=%0d required 0", dp_cnt); end
    checks++; if (an_low(3) !== 15) begin errors++; $display("FAIL en_d3_on: low=%0d required 15", an_low(3)); end
    bus.digit_en = 4'hF;
    wait_frame();
    capture();
    dp_cnt = 0; dp_bad = 0;
    for (int k = 0; k < 64; k++) begin
      if (dp_s[k] == 1'b0) dp_cnt++;
      if (dp_s[k] == 1'b0 && an_s[k] != 4'b1011) dp_bad++;
    end
    checks++; if (dp_cnt !== 15) begin errors++; $display("FAIL dp_on: low=%0d required 15", dp_cnt); end
    checks++; if (dp_bad !== 0) begin errors++; $display("FAIL dp_align: stray=%0d required 0", dp_bad); end
    bus.dp = 4'h0;
  endtask

  task automatic test_async_reset();
    wait_frame();
    repeat (5) @(negedge clk);
    checks++; if (bus.AN !== 4'b1110) begin errors++; $display("FAIL arst_pre_an: got %b required 1110", bus.AN); end
    #2 clr_n = 1'b0;
    #1;
    checks++; if (bus.AN !== 4'hF) begin errors++; $display("FAIL arst_an: got %h required f", bus.AN); end
    checks++; if (bus.SEG !== 7'h7F) begin errors++; $display("FAIL arst_seg: got %h required 7f", bus.SEG); end
    checks++; if (bus.DP !== 1'b1) begin errors++; $display("FAIL arst_dp: got %b required 1", bus.DP); end
    checks++; if (bus.S !== 2'd0) begin errors++; $display("FAIL arst_s: got %0d required 0", bus.S); end
    bus.value = 16'h00A9;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.AN !== 4'hF) begin errors++; $display("FAIL arst_rel_guard: got %b required 1111", bus.AN); end
    @(negedge clk);
    checks++; if (bus.AN !== 4'b1110) begin errors++; $display("FAIL arst_rel_an: got %b required 1110", bus.AN); end
    checks++; if (bus.SEG !== 7'h10) begin errors++; $display("FAIL arst_reload_seg: got %h required 10", bus.SEG); end
    checks++; if (bus.S !== 2'd0) begin errors++; $display("FAIL arst_rel_s: got %0d required 0", bus.S); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_brightness();
    test_lz_blank();
    test_midframe();
    test_dp_enable();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
